regs_bank_ctrl: RTL and testbench
=================================

Name: regs_bank_ctrl

Overview:
- Parametrised register bank that owns the register storage and exposes it to several bus masters.
- Bulk-loads initial values from the parallel regi vector and drives all current values on rego.
- Arbitrates NUM_PORTS addressed read/write ports with valid/ready handshakes.
- Enforces the per-register read-only mask.

Parameters:
- DATA_WIDTH, 8, bits per register.
- DATA_DEPTH, 16, number of registers (>=2).
- ADDR_WIDTH, $clog2(DATA_DEPTH), request address width.
- NUM_PORTS, 2, number of bus request ports (1..8).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- load_regs  in  1  pulse that starts a bulk load from regi.
- regi  in  DATA_DEPTH*DATA_WIDTH  initial values; register i is slice [i*DATA_WIDTH +: DATA_WIDTH].
- mode_mask  in  DATA_DEPTH  per-register mode: 1 = read-only to bus writes, 0 = read/write.
- rego  out  DATA_DEPTH*DATA_WIDTH  current register values, same slicing as regi.
- busy  out  1  high while a bulk load is in progress.
- load_done  out  1  one-cycle pulse after the last register is loaded.
- req_valid  in  NUM_PORTS  per-port request valid.
- req_ready  out  NUM_PORTS  per-port accept; at most one bit high per cycle.
- req_we  in  NUM_PORTS  per-port write enable (1 = write).
- req_addr  in  NUM_PORTS*ADDR_WIDTH  per-port register index.
- req_wdata  in  NUM_PORTS*DATA_WIDTH  per-port write data.
- rsp_valid  out  NUM_PORTS  one-cycle response pulse.
- rsp_rdata  out  NUM_PORTS*DATA_WIDTH  response data.
- rsp_err  out  NUM_PORTS  response error flag.

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all registers, rego, busy, load_done, req_ready, rsp_valid, rsp_rdata and rsp_err = 0; FSM to IDLE; round-robin pointer to port 0.
- FSM states: IDLE, LOAD.
- IDLE:
  - load_regs=1 -> LOAD with index=0, busy=1 from the next cycle.
  - Load has priority over bus requests: no req_ready in the cycle load_regs is sampled high.
- LOAD:
  - Each cycle copies regi slice[index] into register[index], then increments index.
  - Loads every register regardless of mode_mask.
  - At index=DATA_DEPTH-1: write the last register, go to IDLE, pulse load_done in the following cycle, drop busy together with the load_done pulse.
  - A full load takes DATA_DEPTH cycles.
  - regi must stay stable until load_done; the block does not snapshot it.
  - load_regs during LOAD is ignored.
  - req_ready=0 on all ports throughout LOAD.
- Arbitration:
  - In IDLE with no load, round-robin among ports with req_valid high; the grant is combinational req_ready for exactly one port.
  - A transfer occurs on req_valid & req_ready.
  - The pointer moves to the granted port + 1 (mod NUM_PORTS).
  - An unserved port holding req_valid is granted within NUM_PORTS cycles.
- Response: registered; rsp_valid pulses on the granted port the cycle after the transfer.
  - Read: rsp_rdata = register value at the transfer cycle; rsp_err=0.
  - Write, mask bit 0: register updated at the clock edge ending the transfer cycle, visible on rego next cycle; rsp_rdata = new value; rsp_err=0.
  - Write, mask bit 1: no update; rsp_rdata = current value; rsp_err=1.
  - Address >= DATA_DEPTH (non-power-of-two depth): no update; rsp_rdata=0; rsp_err=1.
- Throughput: one transfer per cycle, back-to-back.
- mode_mask is sampled combinationally at the transfer cycle.
- Reset mid-LOAD: registers clear to 0; state returns to IDLE; no load_done.

Optional Feature:
- Macro: REGS_BANK_CHANGE_IRQ_EN.
- Defined:
  - Adds ports chg_flags (out, DATA_DEPTH), chg_clr (in, DATA_DEPTH) and irq (out, 1).
  - chg_flags[i] sets sticky when an accepted bus write changes register i's value.
  - chg_clr[i] clears flag i; a simultaneous set wins.
  - irq = |chg_flags, registered. Bulk load never sets flags.
  - Flags and irq reset to 0.
- Undefined: these ports and all associated logic are absent.

Decomposition:
- Package regs_bank_pkg:
  - state enum (IDLE, LOAD);
  - reg_data_t;
  - localparam helper for the index width.
- Sub-module rr_arbiter (parameter N):
  - req vector in, one-hot grant out;
  - pointer advances on a granted transfer.

Test Plan:
- Reset, then load_regs with regi[i]=8'h10+i, DEPTH=16 -> busy high 16 cycles, load_done pulses once, rego slice 5 = 8'h15, req_ready stays 0 during load.
- Port0 writes 8'hA5 to addr 3 with mask=0 -> rsp_valid next cycle, rsp_rdata=8'hA5, rsp_err=0; read addr 3 returns 8'hA5.
- mode_mask[7]=1, port1 writes 8'h3C to addr 7 -> rsp_err=1, register 7 unchanged at 8'h17.
- Both ports hold req_valid for 4 cycles -> grants alternate 0,1,0,1; four responses, no lost or duplicated transfer.
- load_regs and port0 req_valid asserted in the same cycle -> load wins; port0 is accepted only after load_done, then reads the newly loaded value.
- Reset asserted mid-load at index 8 -> rego all 0, busy 0, no load_done; a fresh load then completes normally.

Source files
------------

// File: rtl/regs_bank_pkg.sv
// Shared types and helpers for the register bank controller.
package regs_bank_pkg;

  typedef enum logic [0:0] {StIdle, StLoad} state_e;

  localparam int unsigned RegDataWidth = 8;
  typedef logic [RegDataWidth-1:0] reg_data_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/regs_bank_ctrl_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer moves past the winner on a transfer.
module rr_arbiter
  import regs_bank_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int unsigned PtrW = idx_width(N);

  logic [PtrW-1:0] ptr_q, ptr_d;
  logic            found;
  int unsigned     c;

  always_comb begin
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    c     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      c = 32'(ptr_q) + i;
      if (c >= N) c = c - N;
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && (j == c) && req[j]) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          ptr_d    = (j + 1 >= N) ? '0 : PtrW'(j + 1);
        end
      end
    end
    if (!advance) ptr_d = ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/regs_bank_ctrl.sv
// Register bank with bulk load and round-robin multi-port bus access.
// Optional change tracking and irq when REGS_BANK_CHANGE_IRQ_EN is defined.
module regs_bank_ctrl
  import regs_bank_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DATA_DEPTH = 16,
  parameter int unsigned ADDR_WIDTH = $clog2(DATA_DEPTH),
  parameter int unsigned NUM_PORTS  = 2
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             load_regs,
  input  logic [DATA_DEPTH*DATA_WIDTH-1:0] regi,
  input  logic [DATA_DEPTH-1:0]            mode_mask,
  output logic [DATA_DEPTH*DATA_WIDTH-1:0] rego,
  output logic                             busy,
  output logic                             load_done,
  input  logic [NUM_PORTS-1:0]             req_valid,
  output logic [NUM_PORTS-1:0]             req_ready,
  input  logic [NUM_PORTS-1:0]             req_we,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_PORTS-1:0]             rsp_valid,
  output logic [NUM_PORTS*DATA_WIDTH-1:0]  rsp_rdata,
  output logic [NUM_PORTS-1:0]             rsp_err
`ifdef REGS_BANK_CHANGE_IRQ_EN
  ,
  output logic [DATA_DEPTH-1:0]            chg_flags,
  input  logic [DATA_DEPTH-1:0]            chg_clr,
  output logic                             irq
`endif
);

  localparam int unsigned IdxW = idx_width(DATA_DEPTH);

  state_e                  state_q;
  logic [IdxW-1:0]         idx_q;
  logic                    busy_q, load_done_q;
  logic [DATA_WIDTH-1:0]   regs_q [DATA_DEPTH];
  logic [DATA_WIDTH-1:0]   regs_d [DATA_DEPTH];

  logic                    arb_en, xfer;
  logic [NUM_PORTS-1:0]    grant;

  logic                    sel_we;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    addr_ok, wr_ok, rsp_err_d;
  logic [DATA_WIDTH-1:0]   cur_data, rsp_data;

  logic [NUM_PORTS-1:0]            rsp_valid_q, rsp_err_q;
  logic [NUM_PORTS*DATA_WIDTH-1:0] rsp_rdata_q;

  // A pending load blocks grants in the very cycle it is requested.
  assign arb_en = (state_q == StIdle) && !load_regs;

  rr_arbiter #(
    .N(NUM_PORTS)
  ) u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    (req_valid & {NUM_PORTS{arb_en}}),
    .advance(xfer),
    .grant  (grant)
  );

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (grant[p]) begin
        sel_we    = req_we[p];
        sel_addr  = req_addr[p*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[p*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign addr_ok   = {1'b0, sel_addr} < (ADDR_WIDTH+1)'(DATA_DEPTH);
  assign cur_data  = addr_ok ? regs_q[sel_addr] : '0;
  assign wr_ok     = xfer && sel_we && addr_ok && !mode_mask[sel_addr];
  assign rsp_err_d = !addr_ok || (sel_we && mode_mask[sel_addr]);
  assign rsp_data  = wr_ok ? sel_wdata : cur_data;

  always_comb begin
    regs_d = regs_q;
    if (state_q == StLoad) regs_d[idx_q] = regi[idx_q*DATA_WIDTH +: DATA_WIDTH];
    if (wr_ok) regs_d[sel_addr] = sel_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      busy_q      <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      load_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (load_regs) begin
            state_q <= StLoad;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        StLoad: begin
          if (idx_q == IdxW'(DATA_DEPTH - 1)) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            load_done_q <= 1'b1;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DATA_DEPTH; i++) regs_q[i] <= '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= '0;
      rsp_err_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rsp_valid_q <= grant;
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        if (grant[p]) begin
          rsp_rdata_q[p*DATA_WIDTH +: DATA_WIDTH] <= rsp_data;
          rsp_err_q[p]                            <= rsp_err_d;
        end
      end
    end
  end

  always_comb begin
    rego = '0;
    for (int unsigned i = 0; i < DATA_DEPTH; i++) rego[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end

  assign busy      = busy_q;
  assign load_done = load_done_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

`ifdef REGS_BANK_CHANGE_IRQ_EN
  logic [DATA_DEPTH-1:0] chg_flags_q, chg_flags_d;
  logic                  irq_q;

  // Set beats clear; only bus writes that actually change the value count.
  always_comb begin
    chg_flags_d = chg_flags_q & ~chg_clr;
    if (wr_ok && (sel_wdata != regs_q[sel_addr])) chg_flags_d[sel_addr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_flags_q <= '0;
      irq_q       <= 1'b0;
    end else begin
      chg_flags_q <= chg_flags_d;
      irq_q       <= |chg_flags_d;
    end
  end

  assign chg_flags = chg_flags_q;
  assign irq       = irq_q;
`else
  // Change tracking absent: no flag storage and no irq in this build.
`endif

endmodule

// File: tb/tb_regs_bank_ctrl.sv
// Directed, table-driven bench for regs_bank_ctrl (default parameters).
module tb_regs_bank_ctrl;

  localparam int DW = 8;
  localparam int DD = 16;
  localparam int AW = 4;
  localparam int NP = 2;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            load_regs = 1'b0;
  logic [DD*DW-1:0] regi = '0;
  logic [DD-1:0]   mode_mask = '0;
  logic [DD*DW-1:0] rego;
  logic            busy, load_done;
  logic [NP-1:0]   req_valid = '0;
  logic [NP-1:0]   req_ready;
  logic [NP-1:0]   req_we = '0;
  logic [NP*AW-1:0] req_addr = '0;
  logic [NP*DW-1:0] req_wdata = '0;
  logic [NP-1:0]   rsp_valid;
  logic [NP*DW-1:0] rsp_rdata;
  logic [NP-1:0]   rsp_err;

  regs_bank_ctrl #(
    .DATA_WIDTH(DW),
    .DATA_DEPTH(DD),
    .ADDR_WIDTH(AW),
    .NUM_PORTS (NP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_regs(load_regs),
    .regi     (regi),
    .mode_mask(mode_mask),
    .rego     (rego),
    .busy     (busy),
    .load_done(load_done),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [DD*DW-1:0] act, input logic [DD*DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int               port;
    logic             we;
    logic [AW-1:0]    addr;
    logic [DW-1:0]    wdata;
    logic [DD-1:0]    mask;
    logic [DW-1:0]    exp_rdata;
    logic             exp_err;
    logic [DW-1:0]    exp_reg;
  } vec_t;

  vec_t vecs[8];

  task automatic fill_regi(input logic [DW-1:0] base);
    for (int i = 0; i < DD; i++) regi[i*DW +: DW] = base + DW'(i);
  endtask

  // Called at posedge+1; returns at posedge+1 after the load window.
  task automatic do_load(input logic clear_valid, output int busy_cnt, output int done_cnt,
                         output int ready_bad);
    busy_cnt  = 0;
    done_cnt  = 0;
    ready_bad = 0;
    load_regs = 1'b1;
    @(negedge clk);
    check("ready_in_load_cycle", req_ready, '0);
    @(posedge clk); #1;
    load_regs = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (load_done) done_cnt++;
      if (busy && (req_ready != '0)) ready_bad++;
      if (clear_valid && !busy) req_valid = '0;
    end
    @(posedge clk); #1;
  endtask

  task automatic apply_vec(input vec_t v, input int k);
    logic [NP-1:0] onehot;
    onehot    = NP'(1) << v.port;
    mode_mask = v.mask;
    req_valid = onehot;
    req_we    = v.we ? onehot : '0;
    req_addr  = {NP{v.addr}};
    req_wdata = {NP{v.wdata}};
    @(negedge clk);
    check($sformatf("vec%0d_ready", k), req_ready, onehot);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check($sformatf("vec%0d_rsp_valid", k), rsp_valid, onehot);
    check($sformatf("vec%0d_rdata", k), rsp_rdata[v.port*DW +: DW], v.exp_rdata);
    check($sformatf("vec%0d_err", k), |(rsp_err & onehot), v.exp_err);
    check($sformatf("vec%0d_reg", k), rego[v.addr*DW +: DW], v.exp_reg);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bc, dc, rb, cyc, cnt0, cnt1, done_seen;
    logic granted;

    vecs[0] = '{0, 1'b1, 4'd3,  8'hA5, 16'h0000, 8'hA5, 1'b0, 8'hA5};
    vecs[1] = '{0, 1'b0, 4'd3,  8'h00, 16'h0000, 8'hA5, 1'b0, 8'hA5};
    vecs[2] = '{1, 1'b1, 4'd7,  8'h3C, 16'h0080, 8'h17, 1'b1, 8'h17};
    vecs[3] = '{1, 1'b0, 4'd7,  8'h00, 16'h0080, 8'h17, 1'b0, 8'h17};
    vecs[4] = '{1, 1'b1, 4'd0,  8'h5A, 16'h0000, 8'h5A, 1'b0, 8'h5A};
    vecs[5] = '{0, 1'b0, 4'd15, 8'h00, 16'h0000, 8'h1F, 1'b0, 8'h1F};
    vecs[6] = '{0, 1'b1, 4'd15, 8'hFF, 16'h8000, 8'h1F, 1'b1, 8'h1F};
    vecs[7] = '{1, 1'b1, 4'd15, 8'h00, 16'h0000, 8'h00, 1'b0, 8'h00};

    // Reset state
    #12;
    check("rst_rego", rego, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_load_done", load_done, 1'b0);
    check("rst_rsp_valid", rsp_valid, '0);
    check("rst_rsp_err", rsp_err, '0);
    check("rst_rsp_rdata", rsp_rdata, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Bulk load with both ports requesting throughout
    fill_regi(8'h10);
    req_valid = 2'b11;
    do_load(1'b1, bc, dc, rb);
    check("load_busy_cycles", bc, 16);
    check("load_done_pulses", dc, 1);
    check("load_ready_blocked", rb, 0);
    check("load_rego_slice5", rego[5*DW +: DW], 8'h15);
    check("load_rego_all", rego, regi);
    check("load_no_rsp", rsp_valid, '0);

    for (int k = 0; k < 8; k++) apply_vec(vecs[k], k);

    // Both ports contend; pointer is at port 0 after the last vector
    mode_mask = '0;
    req_we    = '0;
    req_addr  = {4'd0, 4'd3};
    req_valid = 2'b11;
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("rr_grant%0d", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      if (rsp_valid[0]) cnt0++;
      if (rsp_valid[1]) cnt1++;
      @(posedge clk); #1;
    end
    req_valid = '0;
    @(negedge clk);
    if (rsp_valid[0]) cnt0++;
    if (rsp_valid[1]) cnt1++;
    check("rr_last_rsp", rsp_valid, 2'b10);
    check("rr_rdata_p0", rsp_rdata[0 +: DW], 8'hA5);
    check("rr_rdata_p1", rsp_rdata[DW +: DW], 8'h5A);
    @(posedge clk); #1;
    @(negedge clk);
    check("rr_no_extra_rsp", rsp_valid, '0);
    check("rr_count_p0", cnt0, 2);
    check("rr_count_p1", cnt1, 2);
    @(posedge clk); #1;

    // Load and request in the same cycle: load wins
    fill_regi(8'h40);
    load_regs = 1'b1;
    req_valid = 2'b01;
    req_we    = '0;
    req_addr  = {4'd0, 4'd5};
    @(negedge clk);
    check("prio_ready_blocked", req_ready, '0);
    @(posedge clk); #1;
    load_regs = 1'b0;
    cyc = 0;
    done_seen = 0;
    granted = 1'b0;
    while (cyc < 40 && !granted) begin
      @(negedge clk);
      cyc++;
      if (load_done) done_seen = 1;
      if (req_ready[0]) granted = 1'b1;
    end
    check("prio_granted", granted, 1'b1);
    check("prio_grant_cycle", cyc, 17);
    check("prio_after_done", done_seen, 1);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    check("prio_rsp_valid", rsp_valid, 2'b01);
    check("prio_rdata", rsp_rdata[0 +: DW], 8'h45);
    @(posedge clk); #1;

    // Reset in the middle of a load
    load_regs = 1'b1;
    @(posedge clk); #1;
    load_regs = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    check("mid_busy", busy, 1'b1);
    check("mid_reg7_loaded", rego[7*DW +: DW], 8'h47);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rego", rego, '0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_load_done", load_done, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dc = 0;
    bc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (load_done) dc++;
      if (busy) bc++;
    end
    check("mid_no_load_done", dc, 0);
    check("mid_stays_idle", bc, 0);
    @(posedge clk); #1;

    fill_regi(8'h80);
    do_load(1'b0, bc, dc, rb);
    check("reload_busy_cycles", bc, 16);
    check("reload_done_pulses", dc, 1);
    check("reload_rego", rego, regi);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
